// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   - opcode values of the 5-bit OpFn field
//   - ALU function codes
//   - ctrl_t     : datapath control bundle driven for the stage-1 instruction
//   - sb_entry_t : one in-flight destination record in the hazard scoreboard
package pipe_ctrl_pkg;

  localparam int PIPE_OP_W      = 5;
  localparam int PIPE_REG_AW    = 3;
  localparam int PIPE_HAZ_DEPTH = 3;
  localparam int PIPE_CNT_W     = 8;

  localparam logic [PIPE_OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [PIPE_OP_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [PIPE_OP_W-1:0] OP_AND  = 5'b00010;
  localparam logic [PIPE_OP_W-1:0] OP_OR   = 5'b00011;
  localparam logic [PIPE_OP_W-1:0] OP_SLT  = 5'b00100;
  localparam logic [PIPE_OP_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [PIPE_OP_W-1:0] OP_LW   = 5'b01001;
  localparam logic [PIPE_OP_W-1:0] OP_SW   = 5'b01010;
  localparam logic [PIPE_OP_W-1:0] OP_BEQ  = 5'b01011;
  localparam logic [PIPE_OP_W-1:0] OP_J    = 5'b01100;
  localparam logic [PIPE_OP_W-1:0] OP_HALT = 5'b11111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef struct packed {
    logic       nia;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_fn;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic                   valid;   // entry will write a register
    logic [PIPE_REG_AW-1:0] dest;
    logic                   is_br;   // entry is a BEQ (resolves in stage 3)
  } sb_entry_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational OpFn decoder.
//   opfn_i    : opcode of the stage-1 instruction
//   ctrl_o    : datapath control bundle (all zero for NOP/illegal/HALT)
//   use_a_o   : instruction reads ra
//   use_b_o   : instruction reads rb
//   is_br_o   : instruction is BEQ
//   is_halt_o : instruction is HALT
//   illegal_o : opcode is not in the instruction set
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [PIPE_OP_W-1:0] opfn_i,
  output ctrl_t                ctrl_o,
  output logic                 use_a_o,
  output logic                 use_b_o,
  output logic                 is_br_o,
  output logic                 is_halt_o,
  output logic                 illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_NOP;
    use_a_o   = 1'b0;
    use_b_o   = 1'b0;
    is_br_o   = 1'b0;
    is_halt_o = 1'b0;
    illegal_o = 1'b0;
    case (opfn_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        // R-type: the low three OpFn bits are the ALU function
        ctrl_o.alu_fn    = opfn_i[2:0];
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        use_a_o          = 1'b1;
        use_b_o          = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_fn    = ALU_ADD;
        use_a_o          = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_fn     = ALU_ADD;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        use_a_o           = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        use_a_o          = 1'b1;
        use_b_o          = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_fn = ALU_SUB;
        use_a_o       = 1'b1;
        use_b_o       = 1'b1;
        is_br_o       = 1'b1;
      end
      OP_J: begin
        ctrl_o.nia = 1'b1;
      end
      OP_HALT: begin
        is_halt_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central controller of the 5-stage pipeline (no forwarding).
//   clk, rst        : clock, asynchronous active-low reset
//   opfn, ra, rb, rd: stage-1 instruction fields
//   alubeq          : ALU equality flag of the stage-3 instruction
//   nia..mem_to_reg : datapath controls for the stage-1 instruction
//   pc_en, bubble   : PC/IR advance, load zero controls into the stage-1 latch
//   br_taken        : PC source is the branch target
//   halted, illegal : sticky status flags
//   stall_cnt       : saturating count of RAW stall cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W      = PIPE_OP_W,
  parameter int REG_AW    = PIPE_REG_AW,
  parameter int HAZ_DEPTH = PIPE_HAZ_DEPTH,
  parameter int CNT_W     = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opfn,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic              alubeq,
  output logic              nia,
  output logic              reg_dst,
  output logic              reg_write,
  output logic              alu_src,
  output logic [2:0]        alu_fn,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_to_reg,
  output logic              pc_en,
  output logic              bubble,
  output logic              br_taken,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t dec_ctrl;
  logic  dec_use_a;
  logic  dec_use_b;
  logic  dec_is_br;
  logic  dec_is_halt;
  logic  dec_illegal;

  pipe_ctrl_decode u_decode (
    .opfn_i    (opfn),
    .ctrl_o    (dec_ctrl),
    .use_a_o   (dec_use_a),
    .use_b_o   (dec_use_b),
    .is_br_o   (dec_is_br),
    .is_halt_o (dec_is_halt),
    .illegal_o (dec_illegal)
  );

  // Scoreboard: entry 0 = stage 2, entry 1 = stage 3, entry 2 = stage 4.
  sb_entry_t sb_q [HAZ_DEPTH];
  sb_entry_t sb_d [HAZ_DEPTH];

  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // RAW detection: every in-flight destination against both sources.
  logic [HAZ_DEPTH-1:0] hit_a;
  logic [HAZ_DEPTH-1:0] hit_b;

  for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_cmp
    assign hit_a[gi] = sb_q[gi].valid && (sb_q[gi].dest == ra);
    assign hit_b[gi] = sb_q[gi].valid && (sb_q[gi].dest == rb);
  end

  logic raw_hazard;
  logic flush;

  assign raw_hazard = (dec_use_a && (|hit_a)) || (dec_use_b && (|hit_b));
  // The BEQ resolves in stage 3, i.e. scoreboard entry 1.
  assign flush      = sb_q[1].is_br && alubeq;

  ctrl_t ctrl_out;
  logic  issue;
  logic  count_stall;
  logic  set_halt;
  logic  set_illegal;

  // Action select, highest priority first.
  always_comb begin
    ctrl_out    = CTRL_NOP;
    issue       = 1'b0;
    count_stall = 1'b0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    pc_en       = 1'b0;
    bubble      = 1'b1;
    br_taken    = 1'b0;
    if (!rst) begin
      // held in reset: everything stays at its safe default
    end else if (flush) begin
      br_taken = 1'b1;
      pc_en    = 1'b1;
    end else if (halted_q) begin
      // frozen: bubbles only, the scoreboard drains
    end else if (dec_is_halt) begin
      set_halt = 1'b1;
    end else if (raw_hazard) begin
      count_stall = 1'b1;
    end else begin
      issue       = 1'b1;
      pc_en       = 1'b1;
      bubble      = 1'b0;
      ctrl_out    = dec_ctrl;
      set_illegal = dec_illegal;
    end
  end

  always_comb begin
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].valid = dec_ctrl.reg_write;
      sb_d[0].dest  = dec_ctrl.reg_dst ? rd : rb;
      sb_d[0].is_br = dec_is_br;
    end
    for (int k = 1; k < HAZ_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    // A taken branch squashes the instruction that was in stage 2.
    if (flush) begin
      sb_d[1] = '0;
    end
  end

  always_comb begin
    halted_d    = halted_q | set_halt;
    illegal_d   = illegal_q | set_illegal;
    stall_cnt_d = stall_cnt_q;
    if (count_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign nia        = ctrl_out.nia;
  assign reg_dst    = ctrl_out.reg_dst;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src    = ctrl_out.alu_src;
  assign alu_fn     = ctrl_out.alu_fn;
  assign mem_write  = ctrl_out.mem_write;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] C_ADD  = 5'd0;
  localparam logic [4:0] C_ADDI = 5'd8;
  localparam logic [4:0] C_LW   = 5'd9;
  localparam logic [4:0] C_SW   = 5'd10;
  localparam logic [4:0] C_BEQ  = 5'd11;
  localparam logic [4:0] C_J    = 5'd12;
  localparam logic [4:0] C_HALT = 5'd31;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] opfn = '0;
  logic [2:0] ra = '0, rb = '0, rd = '0;
  logic       alubeq = 1'b0;
  logic       nia, reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg;
  logic [2:0] alu_fn;
  logic       pc_en, bubble, br_taken, halted, illegal;
  logic [7:0] stall_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .opfn(opfn), .ra(ra), .rb(rb), .rd(rd), .alubeq(alubeq),
    .nia(nia), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .alu_fn(alu_fn), .mem_write(mem_write), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .pc_en(pc_en), .bubble(bubble), .br_taken(br_taken),
    .halted(halted), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what each instruction class means, and which
  // instructions are still in flight (stages 2, 3, 4) with their results.
  typedef enum {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_BAD} kind_t;
  typedef struct packed {
    bit       writes;
    bit [2:0] dst;
    bit       branch;
  } flight_t;

  flight_t  inflight [3];
  bit       m_halted;
  bit       m_illegal;
  int       m_stalls;
  int       cyc = 0;

  function automatic kind_t kind_of(input logic [4:0] op);
    if (op <= 5'd4) return K_R;
    case (op)
      5'd8:    return K_ADDI;
      5'd9:    return K_LW;
      5'd10:   return K_SW;
      5'd11:   return K_BEQ;
      5'd12:   return K_J;
      5'd31:   return K_HALT;
      default: return K_BAD;
    endcase
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) inflight[s] = '0;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    m_stalls  = 0;
  endfunction

  // One clock of stimulus: apply at posedge+1, compare at posedge+4, advance.
  task automatic step(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] d, input logic beq);
    kind_t k;
    bit    ua, ub, raw, fl, iss;
    bit    e_nia, e_rdst, e_rw, e_asrc, e_mw, e_mr, e_m2r, e_pc, e_bub, e_br;
    int    e_fn;
    flight_t nxt;
    opfn = op; ra = a; rb = b; rd = d; alubeq = beq;
    if (!rst) model_reset();
    k  = kind_of(op);
    ua = k inside {K_R, K_ADDI, K_LW, K_SW, K_BEQ};
    ub = k inside {K_R, K_SW, K_BEQ};
    raw = 1'b0;
    for (int s = 0; s < 3; s++)
      if (inflight[s].writes && ((ua && inflight[s].dst == a) || (ub && inflight[s].dst == b)))
        raw = 1'b1;
    fl  = rst && inflight[1].branch && beq;
    iss = rst && !fl && !m_halted && (k != K_HALT) && !raw;
    {e_nia, e_rdst, e_rw, e_asrc, e_mw, e_mr, e_m2r, e_br} = '0;
    e_fn  = 0;
    e_pc  = iss || fl;
    e_bub = !iss;
    e_br  = fl;
    if (iss) begin
      case (k)
        K_R:    begin e_rdst = 1; e_rw = 1; e_fn = int'(op); end
        K_ADDI: begin e_asrc = 1; e_rw = 1; end
        K_LW:   begin e_asrc = 1; e_rw = 1; e_mr = 1; e_m2r = 1; end
        K_SW:   begin e_asrc = 1; e_mw = 1; end
        K_BEQ:  e_fn = 1;
        K_J:    e_nia = 1;
        default: ;
      endcase
    end
    #3;
    check("nia", 32'(nia), 32'(e_nia));
    check("reg_dst", 32'(reg_dst), 32'(e_rdst));
    check("reg_write", 32'(reg_write), 32'(e_rw));
    check("alu_src", 32'(alu_src), 32'(e_asrc));
    check("alu_fn", 32'(alu_fn), 32'(e_fn));
    check("mem_write", 32'(mem_write), 32'(e_mw));
    check("mem_read", 32'(mem_read), 32'(e_mr));
    check("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("bubble", 32'(bubble), 32'(e_bub));
    check("br_taken", 32'(br_taken), 32'(e_br));
    check("halted", 32'(halted), 32'(m_halted));
    check("illegal", 32'(illegal), 32'(m_illegal));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    $display("cyc %0d rst=%0b op=%0d ra=%0d rb=%0d rd=%0d beq=%0b -> pc_en=%0b bubble=%0b br=%0b halted=%0b stalls=%0d",
             cyc, rst, op, a, b, d, beq, pc_en, bubble, br_taken, halted, stall_cnt);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      nxt = '0;
      if (iss) begin
        nxt.writes = e_rw;
        nxt.dst    = e_rdst ? d : b;
        nxt.branch = (k == K_BEQ);
      end
      inflight[2] = inflight[1];
      inflight[1] = fl ? flight_t'('0) : inflight[0];
      inflight[0] = nxt;
      if (rst && !fl && !m_halted && k == K_HALT) m_halted = 1'b1;
      if (iss && k == K_BAD) m_illegal = 1'b1;
      if (rst && !fl && !m_halted && k != K_HALT && raw && m_stalls < 255) m_stalls++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(C_J, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic random_op(output logic [4:0] op);
    int r;
    r = $urandom_range(0, 99);
    if (r < 40)      op = 5'($urandom_range(0, 4));
    else if (r < 50) op = C_ADDI;
    else if (r < 60) op = C_LW;
    else if (r < 68) op = C_SW;
    else if (r < 80) op = C_BEQ;
    else if (r < 87) op = C_J;
    else if (r < 89) op = C_HALT;
    else             op = 5'($urandom_range(0, 31));
  endtask

  initial begin
    logic [4:0] rop;
    model_reset();
    @(posedge clk);
    #1;
    // Held in reset: forced outputs.
    step(C_ADD, 3'd1, 3'd2, 3'd3, 1'b0);
    rst = 1'b1;

    // ADD r3,r1,r2 on an idle scoreboard.
    step(C_ADD, 3'd1, 3'd2, 3'd3, 1'b0);
    idle(3);

    // LW r2 then dependent ADD: three stalls, issue on the fourth cycle.
    step(C_LW, 3'd1, 3'd2, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(C_ADD, 3'd2, 3'd1, 3'd4, 1'b0);
    check("lw_add_stalls", 32'(stall_cnt), 32'd3);
    idle(3);

    // BEQ, two ADDs, taken when BEQ reaches stage 3; r7 writer is squashed.
    step(C_BEQ, 3'd5, 3'd6, 3'd0, 1'b0);
    step(C_ADD, 3'd0, 3'd0, 3'd7, 1'b0);
    step(C_ADD, 3'd0, 3'd0, 3'd6, 1'b1);
    step(C_ADD, 3'd7, 3'd7, 3'd1, 1'b0);
    check("flush_no_stall", 32'(stall_cnt), 32'd3);
    idle(3);

    // Flush beats a pending RAW stall, then flush beats HALT.
    step(C_BEQ, 3'd0, 3'd0, 3'd0, 1'b0);
    step(C_LW, 3'd0, 3'd2, 3'd0, 1'b0);
    step(C_ADD, 3'd2, 3'd2, 3'd5, 1'b1);
    idle(3);
    step(C_BEQ, 3'd0, 3'd0, 3'd0, 1'b0);
    step(C_LW, 3'd0, 3'd2, 3'd0, 1'b0);
    step(C_HALT, 3'd0, 3'd0, 3'd0, 1'b1);
    check("flush_beats_halt", 32'(halted), 32'd0);
    check("flush_beats_stall", 32'(stall_cnt), 32'd3);
    idle(3);

    // HALT: sticky, PC frozen, stall counter frozen while draining.
    step(C_ADDI, 3'd0, 3'd3, 3'd0, 1'b0);
    step(C_HALT, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(C_ADD, 3'd3, 3'd3, 3'd1, 1'b0);
    check("halt_cnt_frozen", 32'(stall_cnt), 32'd3);

    // Reset, illegal opcode, then reset during a stall.
    rst = 1'b0;
    step(C_J, 3'd0, 3'd0, 3'd0, 1'b0);
    rst = 1'b1;
    step(5'b10101, 3'd0, 3'd0, 3'd0, 1'b0);
    step(C_LW, 3'd1, 3'd2, 3'd0, 1'b0);
    check("illegal_sticky", 32'(illegal), 32'd1);
    step(C_ADD, 3'd2, 3'd1, 3'd4, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_mid_pc_en", 32'(pc_en), 32'd0);
    check("rst_mid_bubble", 32'(bubble), 32'd1);
    #1;
    step(C_ADD, 3'd2, 3'd1, 3'd4, 1'b0);
    rst = 1'b1;
    step(C_ADD, 3'd2, 3'd1, 3'd4, 1'b0);
    check("post_rst_cnt", 32'(stall_cnt), 32'd0);

    // Randomized segments separated by resets.
    for (int seg = 0; seg < 20; seg++) begin
      for (int i = 0; i < 60; i++) begin
        random_op(rop);
        step(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      rst = 1'b0;
      step(C_J, 3'd0, 3'd0, 3'd0, 1'b0);
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central controller for the 5-stage 8-bit pipeline (fetch/decode, regfile read, ALU, memory, writeback).
- Decodes the 5-bit OpFn of the instruction in stage 1 into datapath control signals.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards; the pipeline has no forwarding.
- Flushes the two younger instructions when a BEQ resolves taken in stage 3. Handles J and HALT, and keeps a stall counter.

Parameters:
- OP_W, 5, OpFn width.
- REG_AW, 3, register address width (8 registers; r0 is not hardwired, all 8 are compared).
- HAZ_DEPTH, 3, scoreboard depth (stages 2..4 hold results not yet written back).
- CNT_W, 8, stall counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- opfn  in  OP_W  opcode of the instruction in stage 1
- ra  in  REG_AW  source A of the stage-1 instruction
- rb  in  REG_AW  source B / I-type destination of the stage-1 instruction
- rd  in  REG_AW  R-type destination of the stage-1 instruction
- alubeq  in  1  ALU equality flag from stage 3
- nia  out  1  PC source is Immj (jump)
- reg_dst  out  1  1 = write rd, 0 = write rb
- reg_write  out  1  register write enable for the issued instruction
- alu_src  out  1  1 = immediate operand
- alu_fn  out  3  ALU function
- mem_write  out  1  store
- mem_read  out  1  load
- mem_to_reg  out  1  1 = writeback from memory
- pc_en  out  1  PC/IR advance enable
- bubble  out  1  stage-1 latch loads zero controls
- br_taken  out  1  PC source is the branch target (pinci)
- halted  out  1  sticky HALT seen
- illegal  out  1  sticky illegal opcode seen
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Opcode encoding (from package):
  - 00000..00100 ADD/SUB/AND/OR/SLT: R-type; alu_fn=opfn[2:0], reg_dst=1, reg_write=1; sources ra, rb.
  - 01000 ADDI: alu_src=1, reg_write=1, reg_dst=0, alu_fn=000; source ra.
  - 01001 LW: as ADDI plus mem_read=1, mem_to_reg=1.
  - 01010 SW: alu_src=1, mem_write=1; sources ra, rb.
  - 01011 BEQ: alu_fn=001; sources ra, rb.
  - 01100 J: nia=1.
  - 11111 HALT.
  - All other codes: decoded as NOP; illegal set sticky on the next edge.
- Scoreboard:
  - HAZ_DEPTH entries {valid, dest, is_br}, shifting every clock: entry0 ← issued instruction, entry k ← entry k-1.
  - An entry's dest is rd if reg_dst=1, else rb. valid = reg_write.
- Stall:
  - Condition: any used source equals the dest of a valid scoreboard entry.
  - On stall: pc_en=0, bubble=1, all controls 0, entry0 ← invalid, stall_cnt += 1 (saturates at all-ones).
- Taken branch:
  - Condition: entry1 (stage 3) has is_br=1 and alubeq=1.
  - br_taken=1, pc_en=1, bubble=1, controls 0.
  - Next edge: entry0 ← invalid and entry1 ← invalid (squashes stages 1 and 2); entry2 ← entry1.
  - Not counted as a stall.
- J: nia=1 in the decode cycle; pc_en=1; no flush (target known in stage 1).
- HALT:
  - Issued as a bubble; halted←1 next edge.
  - While halted: pc_en=0, bubble=1, stall_cnt frozen. The scoreboard keeps shifting invalid entries, so the pipeline drains.
  - Exit from halted only via rst.
- Priority: taken-branch flush > halted > HALT decode > stall > normal issue.
  - A HALT or illegal opcode squashed by a flush has no effect.
- Reset (rst=0, asynchronous):
  - Scoreboard invalid; halted=0, illegal=0, stall_cnt=0.
  - Outputs forced: pc_en=0, bubble=1, all controls 0, br_taken=0.
  - First cycle after release: normal decode.
- Outputs are combinational from stage-1 inputs plus registered state. Decode latency is 0 cycles; the scoreboard updates on the rising edge.

Decomposition:
- Package pipe_ctrl_pkg: opcode localparams, ALU function codes, control-bundle struct, scoreboard-entry struct.
- One sub-module: pipe_ctrl_decode (pure combinational opcode → control bundle + source-use flags + illegal).
- The scoreboard, hazard compare and counters stay in the top.

Test Plan:
- Reset then ADD r3,r1,r2 with an idle scoreboard → reg_dst=1, reg_write=1, alu_fn=000, pc_en=1, bubble=0.
- LW r2 then ADD r4,r2,r1 back-to-back → 3 stall cycles (pc_en=0, bubble=1), ADD issues on the 4th cycle, stall_cnt=3.
- BEQ issued, two following ADDs, alubeq=1 when BEQ is in stage 3 → br_taken=1 for 1 cycle; both ADD entries invalid next cycle; no stall counted.
- BEQ in stage 3 with alubeq=1 while a RAW stall is pending and HALT sits in stage 1 → flush wins; halted stays 0 and stall_cnt is unchanged.
- HALT → halted=1 next edge, pc_en held 0; after 3 cycles all entries invalid; stall_cnt frozen.
- Opcode 10101 → NOP issued, illegal=1 sticky. Then rst=0 mid-stall → immediate pc_en=0, bubble=1; after release stall_cnt=0, illegal=0, halted=0.
